// File: rtl/pause_restart_gen_pkg.sv
// Shared constants and types for the pause/restart button front end.
package pause_restart_gen_pkg;

  localparam int DB_CYCLES_DEFAULT = 16;

  typedef enum logic [0:0] {
    PAUSE_BTN   = 1'b0,
    RESTART_BTN = 1'b1
  } btn_idx_e;

endpackage

// File: rtl/pause_restart_gen_if.sv
// Button inputs and sequence-FSM control outputs of the pause/restart generator.
interface pause_restart_gen_if;

  logic btn_pause;
  logic btn_restart;
  logic pause;
  logic restart;

  modport master (
    output btn_pause,
    output btn_restart,
    input  pause,
    input  restart
  );

  modport slave (
    input  btn_pause,
    input  btn_restart,
    output pause,
    output restart
  );

endinterface

// File: rtl/pause_restart_gen_btn_debounce.sv
// One push-button front end: two-flop synchronizer, counting debouncer and
// rising-edge detector producing a one-cycle press strobe.
module btn_debounce
  import pause_restart_gen_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic          sync1_r;
  logic          sync2_r;
  logic          db_r;
  logic          db_d_r;
  logic [CW-1:0] cnt_r;
  logic          db_s;
  logic [CW-1:0] cnt_s;

  // Debounce next state: any agreement with db restarts the stability count
  always_comb begin
    db_s  = db_r;
    cnt_s = CNT_ZERO;
    if (sync2_r == db_r) begin
      cnt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      db_s  = sync2_r;
      cnt_s = CNT_ZERO;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // Synchronizer, debounce and delayed-level registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      db_r    <= 1'b0;
      db_d_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      db_r    <= db_s;
      db_d_r  <= db_r;
      cnt_r   <= cnt_s;
    end
  end

  // Both operands are flops, so the strobe is glitch-free for the output stage
  assign press = db_r & ~db_d_r;

endmodule

// File: rtl/pause_restart_gen.sv
// Pause level / restart pulse generator driven by two debounced push-buttons.
module pause_restart_gen
  import pause_restart_gen_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  pause_restart_gen_if.slave   bus
);

  logic [1:0] press_s;
  logic       pause_r;
  logic       restart_r;
  logic       pause_s;
  logic       restart_s;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_pause),
    .press (press_s[PAUSE_BTN])
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_restart_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_restart),
    .press (press_s[RESTART_BTN])
  );

  // Output next state: restart wins over a simultaneous pause press
  always_comb begin
    pause_s   = pause_r;
    restart_s = 1'b0;
    if (press_s[RESTART_BTN]) begin
      restart_s = 1'b1;
      pause_s   = 1'b0;
    end else if (press_s[PAUSE_BTN]) begin
      pause_s   = ~pause_r;
    end else begin
      pause_s   = pause_r;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_r   <= 1'b0;
      restart_r <= 1'b0;
    end else begin
      pause_r   <= pause_s;
      restart_r <= restart_s;
    end
  end

  assign bus.pause   = pause_r;
  assign bus.restart = restart_r;

endmodule

// File: tb/tb_pause_restart_gen.sv
// Directed bench for pause_restart_gen (DB_CYCLES=4) with a sliding-window
// reference model checked every cycle plus hand-computed expectations.
module tb_pause_restart_gen;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pause_restart_gen_if bus_if ();

  pause_restart_gen #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last DB+2 raw samples per button, newest in bit 0
  logic [DB+1:0] win_p = '0;
  logic [DB+1:0] win_r = '0;
  logic db_p = 1'b0, db_r = 1'b0, ev_p = 1'b0, ev_r = 1'b0;
  logic exp_pause = 1'b0, exp_restart = 1'b0;

  // Returns {new level, rose}. A raw sample takes two edges to cross the
  // synchronizer, so the level flips once the DB samples taken 2..DB+1
  // edges ago all disagree with it.
  function automatic logic [1:0] deb(input logic [DB+1:0] w, input logic db);
    logic [DB-1:0] seen;
    seen = w[DB+1:2];
    if (seen == {DB{~db}}) return {~db, ~db};
    return {db, 1'b0};
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        win_p = '0; win_r = '0;
        db_p = 1'b0; db_r = 1'b0; ev_p = 1'b0; ev_r = 1'b0;
        exp_pause = 1'b0; exp_restart = 1'b0;
      end else begin
        exp_restart = ev_r;
        if (ev_r) exp_pause = 1'b0;
        else if (ev_p) exp_pause = ~exp_pause;
        win_p = {win_p[DB:0], bus_if.btn_pause};
        win_r = {win_r[DB:0], bus_if.btn_restart};
        {db_p, ev_p} = deb(win_p, db_p);
        {db_r, ev_r} = deb(win_r, db_r);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_pause", bus_if.pause, exp_pause);
      check("model_restart", bus_if.restart, exp_restart);
    end
  end

  // Each step's inputs are sampled by exactly one rising edge
  task automatic run(input logic p, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.btn_pause   = p;
      bus_if.btn_restart = r;
      @(negedge clk);
    end
  endtask

  // Release lands just after a falling edge, so the next rising edge is edge 0
  task automatic do_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_pause", bus_if.pause, 1'b0);
    check("rst_restart", bus_if.restart, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    bus_if.btn_pause   = 1'b0;
    bus_if.btn_restart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("init_pause", bus_if.pause, 1'b0);
    check("init_restart", bus_if.restart, 1'b0);
    #2 rst = 1'b1;

    // Pause held from edge 0 toggles at edge 6 and never again
    run(1'b1, 1'b0, 6);
    check("p_edge5", bus_if.pause, 1'b0);
    run(1'b1, 1'b0, 1);
    check("p_edge6", bus_if.pause, 1'b1);
    check("p_edge6_restart", bus_if.restart, 1'b0);
    run(1'b1, 1'b0, 20);
    check("p_held", bus_if.pause, 1'b1);

    // Release is silent; restart press clears pause at the pulse edge
    run(1'b0, 1'b0, 10);
    check("p_release", bus_if.pause, 1'b1);
    run(1'b0, 1'b1, 6);
    check("r_edge5", bus_if.restart, 1'b0);
    run(1'b0, 1'b1, 1);
    check("r_edge6", bus_if.restart, 1'b1);
    check("r_edge6_pause", bus_if.pause, 1'b0);
    run(1'b0, 1'b1, 1);
    check("r_edge7", bus_if.restart, 1'b0);
    run(1'b0, 1'b1, 10);
    run(1'b0, 1'b0, 10);

    // Bounce: high 3, low 1, then steady -> toggle at edge 10
    do_reset();
    run(1'b1, 1'b0, 3);
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 6);
    check("b_edge9", bus_if.pause, 1'b0);
    run(1'b1, 1'b0, 1);
    check("b_edge10", bus_if.pause, 1'b1);
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 10);

    // Short glitches on either button produce nothing
    run(1'b1, 1'b0, 2);
    run(1'b0, 1'b0, 3);
    run(1'b0, 1'b1, 3);
    run(1'b0, 1'b0, 8);
    check("glitch_pause", bus_if.pause, 1'b1);
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 10);
    check("p_toggle_back", bus_if.pause, 1'b0);

    // Simultaneous press: restart wins, pause stays 0
    do_reset();
    run(1'b1, 1'b1, 6);
    check("both_edge5", bus_if.restart, 1'b0);
    run(1'b1, 1'b1, 1);
    check("both_edge6_r", bus_if.restart, 1'b1);
    check("both_edge6_p", bus_if.pause, 1'b0);
    run(1'b1, 1'b1, 1);
    check("both_edge7_r", bus_if.restart, 1'b0);
    check("both_edge7_p", bus_if.pause, 1'b0);
    run(1'b1, 1'b1, 10);
    run(1'b0, 1'b0, 10);

    // Reset mid-debounce with restart held: one pulse 6 edges after release
    do_reset();
    run(1'b0, 1'b1, 4);
    do_reset();
    run(1'b0, 1'b1, 6);
    check("mid_edge5", bus_if.restart, 1'b0);
    run(1'b0, 1'b1, 1);
    check("mid_edge6", bus_if.restart, 1'b1);
    run(1'b0, 1'b1, 1);
    check("mid_edge7", bus_if.restart, 1'b0);
    run(1'b0, 1'b1, 12);
    check("mid_held", bus_if.restart, 1'b0);
    run(1'b0, 1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
